// File: rtl/counter_cmd_sequencer.sv
// Command sequencer for programmable_counter: queues {mode, value, cycles} commands in a
// small FIFO and plays each one out as a cycle-exact enable/mode/input_value burst.
module counter_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VAL_W = 4,
  parameter int unsigned CYC_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_mode,
  input  logic [VAL_W-1:0]             cmd_value,
  input  logic [CYC_W-1:0]             cmd_cycles,
  input  logic                         abort,
  output logic                         enable,
  output logic [1:0]                   mode,
  output logic [VAL_W-1:0]             input_value,
  output logic                         busy,
  output logic                         cmd_done,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned EntryW = 2 + VAL_W + CYC_W;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  state_e            state_q;
  logic [CYC_W-1:0]  rem_q;

  logic              full, empty, push, pop, head_live;
  logic [1:0]        head_mode;
  logic [VAL_W-1:0]  head_value;
  logic [CYC_W-1:0]  head_cycles;

  always_comb begin
    full      = (count_q == CntW'(DEPTH));
    empty     = (count_q == '0);
    // No pass-through when full: a same-cycle pop never makes room for the push.
    cmd_ready = !reset && !full && !abort;
    push      = cmd_valid && cmd_ready;
    {head_mode, head_value, head_cycles} = mem_q[rd_ptr_q];
    head_live = (head_cycles != '0);
    // In RUN only a live head is taken at the last enable cycle; a zero-cycle
    // head waits to be retired from IDLE.
    pop       = !abort && !empty &&
                ((state_q == StIdle) || ((rem_q == '0) && head_live));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_mode, cmd_value, cmd_cycles};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      enable      <= 1'b0;
      mode        <= 2'b00;
      input_value <= '0;
      busy        <= 1'b0;
      cmd_done    <= 1'b0;
    end else if (abort) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            if (head_live) begin
              state_q     <= StRun;
              enable      <= 1'b1;
              busy        <= 1'b1;
              mode        <= head_mode;
              input_value <= head_value;
              rem_q       <= head_cycles - CYC_W'(1);
            end else begin
              cmd_done <= 1'b1;
            end
          end
        end
        StRun: begin
          if (rem_q != '0) begin
            rem_q <= rem_q - CYC_W'(1);
          end else begin
            cmd_done <= 1'b1;
            if (pop) begin
              mode        <= head_mode;
              input_value <= head_value;
              rem_q       <= head_cycles - CYC_W'(1);
            end else begin
              state_q <= StIdle;
              enable  <= 1'b0;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          enable  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_count = count_q;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer: directed scenarios plus a randomized run checked
// against a queue-based command-playback model.
module tb_counter_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int VAL_W = 4;
  localparam int CYC_W = 8;

  logic             clk, reset, cmd_valid, cmd_ready, abort;
  logic [1:0]       cmd_mode, mode;
  logic [VAL_W-1:0] cmd_value, input_value;
  logic [CYC_W-1:0] cmd_cycles;
  logic             enable, busy, cmd_done;
  logic [2:0]       fifo_count;

  counter_cmd_sequencer #(.DEPTH(DEPTH), .VAL_W(VAL_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_value(cmd_value), .cmd_cycles(cmd_cycles), .abort(abort),
    .enable(enable), .mode(mode), .input_value(input_value), .busy(busy),
    .cmd_done(cmd_done), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: a queue of pending commands plus the number of enable
  // cycles the active command still has to deliver (0 = idle).
  typedef struct {
    logic [1:0]       m;
    logic [VAL_W-1:0] v;
    int               c;
  } cmd_t;

  cmd_t             mq[$];
  int               act;
  logic             m_en, m_busy, m_done;
  logic [1:0]       m_mode;
  logic [VAL_W-1:0] m_val;
  logic             exp_ready, obs_ready;

  // Per-scenario observations of the DUT stream, plus a chained mod-16 counter.
  int en_cycles, done_pulses, cnt_ctr, sidx, en_first, en_last;
  int mode_trace[$];
  int val_hist[16];

  task automatic model_reset();
    mq.delete();
    act = 0; m_en = 0; m_busy = 0; m_done = 0; m_mode = 2'b00; m_val = '0;
  endtask

  task automatic clear_stats();
    en_cycles = 0; done_pulses = 0; cnt_ctr = 0; sidx = 0; en_first = -1; en_last = -1;
    mode_trace.delete();
    for (int i = 0; i < 16; i++) val_hist[i] = 0;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] m, input logic [VAL_W-1:0] val,
                            input logic [CYC_W-1:0] c, input logic ab, input logic rdy);
    cmd_t h, n;
    bit   finishing;
    if (ab) begin
      mq.delete();
      act = 0; m_en = 0; m_busy = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (act > 1) begin
      act--;
    end else begin
      finishing = (act == 1);
      if (finishing) m_done = 1;
      if (mq.size() > 0 && (!finishing || mq[0].c != 0)) begin
        h = mq.pop_front();
        if (h.c != 0) begin
          act = h.c; m_mode = h.m; m_val = h.v;
        end else begin
          act = 0; m_done = 1;
        end
      end else begin
        act = 0;
      end
    end
    m_en = (act > 0);
    m_busy = m_en;
    if (v && rdy) begin
      n.m = m; n.v = val; n.c = int'(c);
      mq.push_back(n);
    end
  endtask

  // One clock: drive after the falling edge, step the model at the rising edge,
  // sample DUT outputs at the next falling edge.
  task automatic cycle(input logic v, input logic [1:0] m, input logic [VAL_W-1:0] val,
                       input logic [CYC_W-1:0] c, input logic ab);
    cmd_valid = v; cmd_mode = m; cmd_value = val; cmd_cycles = c; abort = ab;
    #1;
    exp_ready = (mq.size() < DEPTH) && !ab;
    obs_ready = cmd_ready;
    @(posedge clk);
    model_edge(v, m, val, c, ab, exp_ready);
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    if (enable) begin
      en_cycles++;
      if (en_first < 0) en_first = sidx;
      en_last = sidx;
      mode_trace.push_back(int'(mode));
      val_hist[input_value]++;
      case (mode)
        2'b00:   cnt_ctr = (cnt_ctr + 1) % 16;
        2'b01:   cnt_ctr = (cnt_ctr + 15) % 16;
        2'b10:   cnt_ctr = (cnt_ctr + int'(input_value)) % 16;
        default: cnt_ctr = (cnt_ctr + 16 - int'(input_value)) % 16;
      endcase
    end
    if (cmd_done) done_pulses++;
    sidx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    #2;
    outs = {enable, mode, input_value, busy, cmd_done, fifo_count, cmd_ready, 3'b000};
    total++;
    if (outs !== 16'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0000", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (cmd_ready !== 1'b1 || fifo_count !== 3'd0 || enable !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: got ready=%b count=%0d en=%b want 1 0 0",
               cmd_ready, fifo_count, enable);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    clear_stats();
    cycle(1'b1, 2'b00, 4'd0, 8'd10, 1'b0);
    idle(15);
    total++;
    if (en_first !== 1 || en_last !== 10) begin
      bad++; $display("FAIL single_window: got first=%0d last=%0d want 1 10", en_first, en_last);
    end
    total++;
    if (en_cycles !== 10) begin
      bad++; $display("FAIL single_len: got %0d want 10", en_cycles);
    end
    total++;
    if (cnt_ctr !== 10 || done_pulses !== 1) begin
      bad++; $display("FAIL single_count: got cnt=%0d done=%0d want 10 1", cnt_ctr, done_pulses);
    end
  endtask

  task automatic test_back_to_back();
    int exp_modes[6] = '{0, 0, 0, 2, 2, 3};
    clear_stats();
    cycle(1'b1, 2'b00, 4'd0, 8'd3, 1'b0);
    cycle(1'b1, 2'b10, 4'd3, 8'd2, 1'b0);
    cycle(1'b1, 2'b11, 4'd2, 8'd1, 1'b0);
    idle(8);
    total++;
    if (en_cycles !== 6 || en_last - en_first + 1 !== 6) begin
      bad++;
      $display("FAIL b2b_contig: got len=%0d span=%0d want 6 6", en_cycles, en_last - en_first + 1);
    end
    for (int i = 0; i < 6 && i < mode_trace.size(); i++) begin
      total++;
      if (mode_trace[i] !== exp_modes[i]) begin
        bad++; $display("FAIL b2b_mode[%0d]: got %0d want %0d", i, mode_trace[i], exp_modes[i]);
      end
    end
    total++;
    if (cnt_ctr !== 7 || done_pulses !== 3) begin
      bad++; $display("FAIL b2b_count: got cnt=%0d done=%0d want 7 3", cnt_ctr, done_pulses);
    end
  endtask

  task automatic test_full();
    clear_stats();
    cycle(1'b1, 2'b00, 4'd0, 8'd255, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 2'b10, 4'(k + 1), 8'(k + 1), 1'b0);
      total++;
      if (obs_ready !== (k < 4)) begin
        bad++; $display("FAIL full_ready[%0d]: got %b want %b", k, obs_ready, (k < 4));
      end
    end
    total++;
    if (fifo_count !== 3'd4) begin
      bad++; $display("FAIL full_count: got %0d want 4", fifo_count);
    end
    idle(270);
    for (int k = 1; k <= 5; k++) begin
      total++;
      if (val_hist[k] !== ((k < 5) ? k : 0)) begin
        bad++; $display("FAIL full_played[%0d]: got %0d want %0d", k, val_hist[k], (k < 5) ? k : 0);
      end
    end
    total++;
    if (en_cycles !== 265 || done_pulses !== 5) begin
      bad++; $display("FAIL full_total: got en=%0d done=%0d want 265 5", en_cycles, done_pulses);
    end
  endtask

  task automatic test_zero_abort();
    clear_stats();
    cycle(1'b1, 2'b01, 4'd0, 8'd0, 1'b0);
    idle(4);
    total++;
    if (done_pulses !== 1 || en_cycles !== 0) begin
      bad++; $display("FAIL zero_cycle: got done=%0d en=%0d want 1 0", done_pulses, en_cycles);
    end
    clear_stats();
    cycle(1'b1, 2'b00, 4'd0, 8'd8, 1'b0);
    cycle(1'b1, 2'b00, 4'd0, 8'd4, 1'b0);
    cycle(1'b1, 2'b00, 4'd0, 8'd4, 1'b0);
    idle(1);
    total++;
    if (enable !== 1'b1 || fifo_count !== 3'd2) begin
      bad++; $display("FAIL pre_abort: got en=%b count=%0d want 1 2", enable, fifo_count);
    end
    cycle(1'b1, 2'b00, 4'd0, 8'd5, 1'b1);
    total++;
    if (obs_ready !== 1'b0) begin
      bad++; $display("FAIL abort_ready: got %b want 0", obs_ready);
    end
    total++;
    if (enable !== 1'b0 || fifo_count !== 3'd0 || cmd_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got en=%b count=%0d done=%b busy=%b want 0 0 0 0",
               enable, fifo_count, cmd_done, busy);
    end
    idle(12);
    total++;
    if (done_pulses !== 0 || en_cycles !== 3) begin
      bad++; $display("FAIL abort_after: got done=%0d en=%0d want 0 3", done_pulses, en_cycles);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 2'b00, 4'd0, 8'd20, 1'b0);
    cycle(1'b1, 2'b00, 4'd0, 8'd3, 1'b0);
    cycle(1'b1, 2'b00, 4'd0, 8'd3, 1'b0);
    idle(2);
    total++;
    if (enable !== 1'b1 || fifo_count !== 3'd2) begin
      bad++; $display("FAIL pre_reset: got en=%b count=%0d want 1 2", enable, fifo_count);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (enable !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: got en=%b busy=%b ready=%b count=%0d want 0 0 0 0",
               enable, busy, cmd_ready, fifo_count);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    clear_stats();
    idle(6);
    total++;
    if (en_cycles !== 0 || done_pulses !== 0 || fifo_count !== 3'd0 || obs_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_reset: got en=%0d done=%0d count=%0d ready=%b want 0 0 0 1",
               en_cycles, done_pulses, fifo_count, obs_ready);
    end
  endtask

  task automatic test_random();
    logic             v, ab;
    logic [1:0]       m;
    logic [VAL_W-1:0] val;
    logic [CYC_W-1:0] c;
    for (int i = 0; i < 800; i++) begin
      v   = ($urandom_range(0, 2) != 0);
      m   = 2'($urandom_range(0, 3));
      val = VAL_W'($urandom_range(0, 15));
      c   = CYC_W'($urandom_range(0, 5));
      ab  = ($urandom_range(0, 39) == 0);
      cycle(v, m, val, c, ab);
      total++;
      if (obs_ready !== exp_ready) begin
        bad++; $display("FAIL rnd_ready@%0d: got %b want %b", i, obs_ready, exp_ready);
      end
      total++;
      if (enable !== m_en || busy !== m_busy || cmd_done !== m_done) begin
        bad++;
        $display("FAIL rnd_ctrl@%0d: got en=%b busy=%b done=%b want %b %b %b",
                 i, enable, busy, cmd_done, m_en, m_busy, m_done);
      end
      total++;
      if (fifo_count !== 3'(mq.size())) begin
        bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, fifo_count, mq.size());
      end
      total++;
      if (mode !== m_mode || input_value !== m_val) begin
        bad++;
        $display("FAIL rnd_data@%0d: got mode=%0d val=%0d want %0d %0d",
                 i, mode, input_value, m_mode, m_val);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_value = '0; cmd_cycles = '0;
    abort = 1'b0;
    model_reset();
    clear_stats();
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_zero_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
